// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline controller: instruction codes,
// status codes, the "no register" id and the run/halt state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [2:0] SINS    = 3'd3;
  localparam logic [2:0] SHLT    = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Any status other than AOK that must stop the machine.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Purely combinational hazard detection and the pipeline controls that apply
// while the machine is running.
module pipe_hazard
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       mp,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       set_cc
);

  logic lu;
  logic rp;
  logic m_exc;
  logic w_exc;

  always_comb begin
    lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rp = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    mp = (E_icode == IJXX) && !e_Cnd;
  end

  // A load-use stall takes priority over the ret bubble in D, so D holds.
  always_comb begin
    m_exc    = is_exc(m_stat);
    w_exc    = is_exc(W_stat);
    F_stall  = lu || rp;
    D_stall  = lu;
    D_bubble = mp || (!lu && rp);
    E_bubble = mp || lu;
    M_bubble = m_exc || w_exc;
    W_stall  = w_exc;
    set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: run/halt state machine, F_predPC register,
// hazard controls gated by machine state, and performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      f_predPC,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic [63:0]      F_predPC,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       state,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  state_t cur_state;
  state_t next_state;

  logic h_mp;
  logic h_F_stall;
  logic h_D_stall;
  logic h_D_bubble;
  logic h_E_bubble;
  logic h_M_bubble;
  logic h_W_stall;
  logic h_set_cc;
  logic running;

  pipe_hazard u_hazard (
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .mp       (h_mp),
    .F_stall  (h_F_stall),
    .D_stall  (h_D_stall),
    .D_bubble (h_D_bubble),
    .E_bubble (h_E_bubble),
    .M_bubble (h_M_bubble),
    .W_stall  (h_W_stall),
    .set_cc   (h_set_cc)
  );

  assign running = (cur_state == RUN);
  assign state   = cur_state;

  // Outside RUN the whole pipe is frozen and flushed regardless of hazards.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    if (running) begin
      F_stall  = h_F_stall;
      D_stall  = h_D_stall;
      D_bubble = h_D_bubble;
      E_bubble = h_E_bubble;
      M_bubble = h_M_bubble;
      W_stall  = h_W_stall;
      set_cc   = h_set_cc;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (is_exc(W_stat)) next_state = HALTED;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      cpu_stat  <= SAOK;
    end else begin
      cur_state <= next_state;
      if (running && is_exc(W_stat)) cpu_stat <= W_stat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= RESET_PC;
    end else if (cur_state == IDLE && start) begin
      F_predPC <= RESET_PC;
    end else if (running && !h_F_stall) begin
      F_predPC <= f_predPC;
    end
  end

  // Counters only advance while running and wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      ret_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (running) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (W_stat == SAOK && W_icode != INOP) ret_cnt <= ret_cnt + CNT_W'(1);
      if (h_F_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (h_mp) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random
// traffic compared against a rule-level reference model.
module tb_pipe_ctrl;

  localparam logic [63:0] RESET_PC = 64'h100;
  localparam int          CNT_W    = 32;

  typedef struct {
    logic        start;
    logic [63:0] pc;
    logic [3:0]  D_icode;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_icode;
    logic [3:0]  E_dstM;
    logic        e_Cnd;
    logic [3:0]  M_icode;
    logic [2:0]  m_stat;
    logic [3:0]  W_icode;
    logic [2:0]  W_stat;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] f_predPC = '0;
  logic [3:0] D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [3:0] E_icode = 4'h1, E_dstM = 4'hF, M_icode = 4'h1, W_icode = 4'h1;
  logic e_Cnd = 1'b1;
  logic [2:0] m_stat = 3'd1, W_stat = 3'd1;

  logic [63:0] F_predPC;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0] state;
  logic [2:0] cpu_stat;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, mispred_cnt;

  pipe_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_predPC(f_predPC),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_predPC(F_predPC), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .W_stall(W_stall), .set_cc(set_cc), .state(state), .cpu_stat(cpu_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: 0 idle, 1 running, 2 halted.
  int          m_state;
  logic [2:0]  m_cstat;
  logic [63:0] m_pc;
  logic [31:0] m_cyc, m_ret, m_stall, m_mis;

  logic [6:0]   exp_ctl;
  logic [196:0] exp_regs;
  wire  [6:0]   act_ctl  = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  wire  [196:0] act_regs = {state, cpu_stat, F_predPC, cyc_cnt, ret_cnt, stall_cnt, mispred_cnt};

  function automatic bit bad_stat(input logic [2:0] s);
    return s >= 3'd2 && s <= 3'd4;
  endfunction

  // Returns {mispredict, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}.
  function automatic logic [7:0] model_ctl(input in_t v);
    bit lu, rp, mp;
    lu = (v.E_icode == 4'd5 || v.E_icode == 4'd11) && v.E_dstM != 4'hF &&
         (v.E_dstM == v.d_srcA || v.E_dstM == v.d_srcB);
    rp = (v.D_icode == 4'd9 || v.E_icode == 4'd9 || v.M_icode == 4'd9);
    mp = (v.E_icode == 4'd7) && !v.e_Cnd;
    if (m_state != 1) return {1'b0, 7'b1011110};
    return {mp, lu || rp, lu, mp || (rp && !lu), mp || lu,
            bad_stat(v.m_stat) || bad_stat(v.W_stat), bad_stat(v.W_stat),
            v.E_icode == 4'd6 && !bad_stat(v.m_stat) && !bad_stat(v.W_stat)};
  endfunction

  function automatic in_t quiet(input logic [63:0] pc);
    in_t v;
    v.start = 1'b0; v.pc = pc;
    v.D_icode = 4'h1; v.d_srcA = 4'hF; v.d_srcB = 4'hF;
    v.E_icode = 4'h1; v.E_dstM = 4'hF; v.e_Cnd = 1'b1;
    v.M_icode = 4'h1; v.m_stat = 3'd1; v.W_icode = 4'h1; v.W_stat = 3'd1;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cstat = 3'd1; m_pc = RESET_PC;
    m_cyc = 0; m_ret = 0; m_stall = 0; m_mis = 0;
  endtask

  // Drive one cycle of inputs mid-period and form the expected observation.
  task automatic apply(input in_t v);
    logic [7:0] e;
    @(negedge clk);
    start = v.start; f_predPC = v.pc;
    D_icode = v.D_icode; d_srcA = v.d_srcA; d_srcB = v.d_srcB;
    E_icode = v.E_icode; E_dstM = v.E_dstM; e_Cnd = v.e_Cnd;
    M_icode = v.M_icode; m_stat = v.m_stat; W_icode = v.W_icode; W_stat = v.W_stat;
    #2;
    e = model_ctl(v);
    exp_ctl  = e[6:0];
    exp_regs = {m_state[1:0], m_cstat, m_pc, m_cyc, m_ret, m_stall, m_mis};
  endtask

  // Advance the clock and the model together.
  task automatic tick(input in_t v);
    logic [7:0] e;
    e = model_ctl(v);
    @(posedge clk);
    if (m_state == 1) begin
      m_cyc++;
      if (v.W_stat == 3'd1 && v.W_icode != 4'd1) m_ret++;
      if (e[6]) m_stall++;
      if (e[7]) m_mis++;
      if (!e[6]) m_pc = v.pc;
      if (bad_stat(v.W_stat)) begin m_state = 2; m_cstat = v.W_stat; end
    end else if (m_state == 0 && v.start) begin
      m_state = 1; m_pc = RESET_PC;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    start = 1'b0; D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    E_dstM = 4'hF; e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act_regs !== {2'd0, 3'd1, RESET_PC, 128'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_regs actual=%h required=%h", act_regs, {2'd0, 3'd1, RESET_PC, 128'd0});
    end
    n_checks++;
    if (act_ctl !== 7'b1011110) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl actual=%b required=%b", act_ctl, 7'b1011110);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    in_t v;
    v = quiet(64'h0A); v.start = 1'b1;
    apply(v);
    n_checks++;
    if (act_ctl !== exp_ctl) begin n_fail++; $display("[TB] FAIL start_ctl actual=%b required=%b", act_ctl, exp_ctl); end
    tick(v);
    for (int i = 0; i < 5; i++) begin
      v = quiet(64'h0A);
      apply(v);
      n_checks++;
      if (act_ctl !== exp_ctl) begin n_fail++; $display("[TB] FAIL run_ctl[%0d] actual=%b required=%b", i, act_ctl, exp_ctl); end
      n_checks++;
      if (act_regs !== exp_regs) begin n_fail++; $display("[TB] FAIL run_regs[%0d] actual=%h required=%h", i, act_regs, exp_regs); end
      if (i == 2) begin
        n_checks++;
        if (F_predPC !== 64'h0A || cyc_cnt !== 32'd2) begin
          n_fail++; $display("[TB] FAIL run_pc actual=%h/%0d required=a/2", F_predPC, cyc_cnt);
        end
      end
      tick(v);
    end
  endtask

  task automatic test_load_use();
    in_t v;
    v = quiet(64'h20); v.E_icode = 4'd5; v.E_dstM = 4'd3; v.d_srcA = 4'd3;
    apply(v);
    n_checks++;
    if (act_ctl !== 7'b1101000) begin n_fail++; $display("[TB] FAIL load_use_ctl actual=%b required=%b", act_ctl, 7'b1101000); end
    tick(v);
    v = quiet(64'h28);
    apply(v);
    n_checks++;
    if (act_regs !== exp_regs) begin n_fail++; $display("[TB] FAIL load_use_regs actual=%h required=%h", act_regs, exp_regs); end
    tick(v);
  endtask

  task automatic test_ret();
    in_t v;
    for (int i = 0; i < 3; i++) begin
      v = quiet(64'h40 + 64'(i));
      if (i == 0) v.D_icode = 4'd9;
      if (i == 1) v.E_icode = 4'd9;
      if (i == 2) v.M_icode = 4'd9;
      apply(v);
      n_checks++;
      if (act_ctl !== 7'b1010000) begin n_fail++; $display("[TB] FAIL ret_ctl[%0d] actual=%b required=%b", i, act_ctl, 7'b1010000); end
      n_checks++;
      if (act_regs !== exp_regs) begin n_fail++; $display("[TB] FAIL ret_regs[%0d] actual=%h required=%h", i, act_regs, exp_regs); end
      tick(v);
    end
  endtask

  task automatic test_mispredict();
    in_t v;
    v = quiet(64'h60); v.E_icode = 4'd7; v.e_Cnd = 1'b0;
    apply(v);
    n_checks++;
    if (act_ctl !== 7'b0011000) begin n_fail++; $display("[TB] FAIL mispred_ctl actual=%b required=%b", act_ctl, 7'b0011000); end
    tick(v);
    v = quiet(64'h68);
    apply(v);
    n_checks++;
    if (act_regs !== exp_regs || mispred_cnt !== 32'd1) begin
      n_fail++; $display("[TB] FAIL mispred_regs actual=%h required=%h", act_regs, exp_regs);
    end
    tick(v);
  endtask

  task automatic test_lu_ret();
    in_t v;
    v = quiet(64'h80); v.E_icode = 4'd5; v.E_dstM = 4'd2; v.d_srcB = 4'd2; v.M_icode = 4'd9;
    apply(v);
    n_checks++;
    if (act_ctl !== 7'b1101000) begin n_fail++; $display("[TB] FAIL lu_ret_ctl actual=%b required=%b", act_ctl, 7'b1101000); end
    tick(v);
    v = quiet(64'h88); v.E_icode = 4'd7; v.e_Cnd = 1'b0; v.D_icode = 4'd9;
    apply(v);
    n_checks++;
    if (act_ctl !== 7'b1011000) begin n_fail++; $display("[TB] FAIL mp_ret_ctl actual=%b required=%b", act_ctl, 7'b1011000); end
    tick(v);
  endtask

  task automatic test_exception();
    in_t v;
    for (int i = 0; i < 5; i++) begin
      v = quiet(64'hA0 + 64'(i)); v.E_icode = 4'd6; v.W_icode = 4'd2;
      if (i == 0) v.m_stat = 3'd2;
      if (i == 1) v.W_stat = 3'd2;
      if (i >= 2) v.start = 1'b1;
      apply(v);
      n_checks++;
      if (act_ctl !== exp_ctl) begin n_fail++; $display("[TB] FAIL exc_ctl[%0d] actual=%b required=%b", i, act_ctl, exp_ctl); end
      n_checks++;
      if (act_regs !== exp_regs) begin n_fail++; $display("[TB] FAIL exc_regs[%0d] actual=%h required=%h", i, act_regs, exp_regs); end
      if (i < 2) begin
        n_checks++;
        if (M_bubble !== 1'b1 || set_cc !== 1'b0) begin
          n_fail++; $display("[TB] FAIL exc_mbubble[%0d] actual=%b%b required=10", i, M_bubble, set_cc);
        end
      end
      tick(v);
    end
    n_checks++;
    if (state !== 2'd2 || cpu_stat !== 3'd2) begin
      n_fail++; $display("[TB] FAIL halted actual=%0d/%0d required=2/2", state, cpu_stat);
    end
  endtask

  task automatic test_random();
    in_t v;
    v = quiet(64'h0); v.start = 1'b1;
    apply(v);
    tick(v);
    for (int i = 0; i < 300; i++) begin
      v.start   = ($urandom_range(0, 15) == 0);
      v.pc      = {$urandom, $urandom};
      v.D_icode = 4'($urandom_range(0, 11));
      v.E_icode = 4'($urandom_range(0, 11));
      v.M_icode = 4'($urandom_range(0, 11));
      v.W_icode = 4'($urandom_range(0, 11));
      v.d_srcA  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      v.d_srcB  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      v.E_dstM  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      v.e_Cnd   = 1'($urandom_range(0, 1));
      v.m_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      v.W_stat  = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      apply(v);
      n_checks++;
      if (act_ctl !== exp_ctl) begin n_fail++; $display("[TB] FAIL rand_ctl[%0d] actual=%b required=%b", i, act_ctl, exp_ctl); end
      n_checks++;
      if (act_regs !== exp_regs) begin n_fail++; $display("[TB] FAIL rand_regs[%0d] actual=%h required=%h", i, act_regs, exp_regs); end
      tick(v);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_load_use();
    test_ret();
    test_mispredict();
    test_lu_ret();
    test_exception();
    test_reset();
    test_start();
    test_reset();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencing and hazard controller for the 5-stage Y86-64 pipeline (F/D/E/M/W).
- Owns the F_predPC register.
- Generates per-stage stall/bubble and set_cc controls from load-use, ret and mispredicted-jump conditions.
- Runs a run/halt state machine that freezes the pipe on an exception status reaching W.
- Keeps performance counters for bring-up and verification.
- Sits beside selectPC and the pipeline registers; every pipeline register takes its stall/bubble from here.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset and on start
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; IDLE->RUN
f_predPC  in  64  predicted next PC from fetch
D_icode  in  4  icode in D register
d_srcA  in  4  decode source A (4'hF = none)
d_srcB  in  4  decode source B (4'hF = none)
E_icode  in  4  icode in E register
E_dstM  in  4  E-stage memory destination register
e_Cnd  in  1  execute condition result
M_icode  in  4  icode in M register
m_stat  in  3  memory-stage status
W_icode  in  4  icode in W register
W_stat  in  3  W-stage status
F_predPC  out  64  registered predicted PC, feeds selectPC
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
set_cc  out  1  enable CC update
state  out  2  IDLE=0, RUN=1, HALTED=2
cpu_stat  out  3  latched machine status
cyc_cnt, ret_cnt, stall_cnt, mispred_cnt  out  CNT_W each  performance counters

Behaviour:
Status encoding: AOK=1, ADR=2, INS=3, HLT=4. "exc(s)" means s is ADR, INS or HLT.

Reset (async, rst_n=0):
- state=IDLE, F_predPC=RESET_PC, cpu_stat=AOK, all counters 0.

Hazard terms (combinational):
- lu = E_icode in {MRMOVQ 5, POPQ B} && E_dstM!=4'hF && (E_dstM==d_srcA || E_dstM==d_srcB)
- rp = RET(9) in {D_icode, E_icode, M_icode}
- mp = E_icode==JXX(7) && !e_Cnd

Outputs in RUN:
- F_stall = lu || rp
- D_stall = lu
- D_bubble = mp || (!lu && rp)
- E_bubble = mp || lu
- M_bubble = exc(m_stat) || exc(W_stat)
- W_stall = exc(W_stat)
- set_cc = E_icode==OPQ(6) && !exc(m_stat) && !exc(W_stat)

Outputs in IDLE and HALTED:
- F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=1
- D_stall=0, set_cc=0

Simultaneous hazards:
- lu together with rp gives D_stall=1, D_bubble=0.
- mp together with rp gives F_stall=1, D_bubble=1, E_bubble=1.

F_predPC:
- RUN && !F_stall: F_predPC <= f_predPC.
- Otherwise F_predPC holds.
- start in IDLE reloads RESET_PC.

State machine:
- IDLE -> RUN on start.
- RUN -> HALTED on the first cycle with exc(W_stat); cpu_stat <= W_stat in that same edge.
- HALTED is sticky; only rst_n leaves it. start is ignored outside IDLE.

Counters (RUN only, wrap modulo 2^CNT_W, no saturation):
- cyc_cnt +1 every RUN cycle.
- ret_cnt +1 when W_stat==AOK && W_icode!=NOP(1); bubbles are not counted.
- stall_cnt +1 when F_stall.
- mispred_cnt +1 when mp.

Reset asserted mid-run returns all state to reset values immediately. Outputs are glitch-free from registered state plus decoded inputs; no combinational path from start to outputs.

Decomposition:
- Package y86_pkg:
  - icode constants (HALT..POPQ)
  - stat codes AOK/ADR/INS/HLT
  - RNONE=4'hF
  - state encoding IDLE/RUN/HALTED
- Sub-module pipe_hazard: purely combinational lu/rp/mp and RUN-mode control equations.
- pipe_ctrl: instantiates pipe_hazard, adds state machine, PC register, counters and IDLE/HALTED override.

Test Plan:
- Reset then start, f_predPC=64'h0A each cycle, no hazards -> F_predPC=64'h0A one cycle after start; all stall/bubble outputs 0; cyc_cnt increments per cycle.
- E_icode=5, E_dstM=3, d_srcA=3 for one cycle -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; F_predPC held; stall_cnt+1.
- D_icode=9, then E_icode=9, then M_icode=9 over 3 cycles -> F_stall=1 and D_bubble=1 each of the 3 cycles; F_predPC unchanged throughout.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; mispred_cnt=1.
- Same cycle E_icode=5 load-use and M_icode=9 -> D_stall=1, D_bubble=0, F_stall=1.
- m_stat=ADR, then W_stat=ADR -> M_bubble=1 and set_cc=0 for E_icode=6; next edge state=HALTED, cpu_stat=2, all counters frozen; start ignored; rst_n low returns state=IDLE, cpu_stat=1.
